// File: rtl/stack_access_unit_if.sv
// Request/response bundle between the control unit and the stack sequencer.
// The control unit is the master; the stack access unit is the slave.

`ifndef SFR_OP_LEN
`define SFR_OP_LEN 4
`endif

interface stack_access_unit_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_pop;
    logic        i_req_two;
    logic [15:0] i_wdata;
    logic        o_rsp_valid;
    logic        o_rsp_err;
    logic [15:0] o_rdata;

    modport master (
        output i_req_valid,
        output i_req_pop,
        output i_req_two,
        output i_wdata,
        input  o_req_ready,
        input  o_rsp_valid,
        input  o_rsp_err,
        input  o_rdata
    );

    modport slave (
        input  i_req_valid,
        input  i_req_pop,
        input  i_req_two,
        input  i_wdata,
        output o_req_ready,
        output o_rsp_valid,
        output o_rsp_err,
        output o_rdata
    );
endinterface

// File: rtl/stack_access_unit.sv
// Stack transaction sequencer: 1/2-byte push and pop against internal RAM.
// Descending stack; SP is owned by the SFR block and stepped via o_sp_op.

`ifndef SFR_OP_LEN
`define SFR_OP_LEN 4
`endif
`ifndef OP_SP_PUSH
`define OP_SP_PUSH 4'h1
`endif
`ifndef OP_SP_POP
`define OP_SP_POP 4'h2
`endif

module stack_access_unit #(
    parameter logic [7:0] STACK_TOP   = 8'h7F,
    parameter logic [7:0] STACK_FLOOR = 8'h08
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    stack_access_unit_if.slave     bus,
    input  logic [7:0]             i_sp,
    output logic [`SFR_OP_LEN-1:0] o_sp_op,
    output logic [7:0]             o_ram_addr,
    output logic                   o_ram_we,
    output logic [7:0]             o_ram_wdata,
    output logic                   o_ram_re,
    input  logic [7:0]             i_ram_rdata
);

    localparam logic [`SFR_OP_LEN-1:0] OP_PUSH = `OP_SP_PUSH;
    localparam logic [`SFR_OP_LEN-1:0] OP_POP  = `OP_SP_POP;
    localparam logic [`SFR_OP_LEN-1:0] OP_NONE = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PUSH,
        S_POP_RD,
        S_POP_CAP,
        S_RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        pop_q;
    logic        two_q;
    logic [15:0] wdata_q;
    logic        idx;
    logic        err_q;
    logic [7:0]  hi_q;
    logic [15:0] rdata_q;

    logic        ready;
    logic        accept;
    logic        last;
    logic [8:0]  sp9;
    logic [8:0]  n9;
    logic        push_err;
    logic        pop_err;
    logic        chk_err;

    assign accept = bus.i_req_valid & ready;
    assign last   = (idx == two_q);

    // Bounds check in 9 bits so neither direction can wrap.
    assign sp9      = {1'b0, i_sp};
    assign n9       = two_q ? 9'd2 : 9'd1;
    assign push_err = sp9 < ({1'b0, STACK_FLOOR} + n9 - 9'd1);
    assign pop_err  = (sp9 + n9) > {1'b0, STACK_TOP};
    assign chk_err  = pop_q ? pop_err : push_err;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (chk_err) begin
                    state_nxt = S_RESP;
                end else if (pop_q) begin
                    state_nxt = S_POP_RD;
                end else begin
                    state_nxt = S_PUSH;
                end
            end
            S_PUSH: begin
                if (last) begin
                    state_nxt = S_RESP;
                end
            end
            S_POP_RD: begin
                state_nxt = S_POP_CAP;
            end
            S_POP_CAP: begin
                state_nxt = last ? S_RESP : S_POP_RD;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Request latch, byte counter and pop data assembly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pop_q   <= 1'b0;
            two_q   <= 1'b0;
            wdata_q <= 16'h0000;
            idx     <= 1'b0;
            err_q   <= 1'b0;
            hi_q    <= 8'h00;
            rdata_q <= 16'h0000;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        pop_q   <= bus.i_req_pop;
                        two_q   <= bus.i_req_two;
                        wdata_q <= bus.i_wdata;
                        err_q   <= 1'b0;
                        idx     <= 1'b0;
                    end
                end
                S_CHECK: begin
                    err_q <= chk_err;
                    idx   <= 1'b0;
                end
                S_PUSH: begin
                    idx <= idx + 1'b1;
                end
                S_POP_CAP: begin
                    idx <= idx + 1'b1;
                    if (!last) begin
                        hi_q <= i_ram_rdata;
                    end else if (two_q) begin
                        rdata_q <= {hi_q, i_ram_rdata};
                    end else begin
                        rdata_q <= {8'h00, i_ram_rdata};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode: RAM strobes, SP op and handshake from the state.
    always_comb begin
        ready           = 1'b0;
        bus.o_rsp_valid = 1'b0;
        bus.o_rsp_err   = 1'b0;
        o_sp_op         = OP_NONE;
        o_ram_addr      = 8'h00;
        o_ram_we        = 1'b0;
        o_ram_wdata     = 8'h00;
        o_ram_re        = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready = 1'b1;
            end
            S_PUSH: begin
                o_ram_we    = 1'b1;
                o_ram_addr  = i_sp;
                o_ram_wdata = idx ? wdata_q[15:8] : wdata_q[7:0];
                o_sp_op     = OP_PUSH;
            end
            S_POP_RD: begin
                o_ram_re   = 1'b1;
                o_ram_addr = i_sp + 8'd1;
                o_sp_op    = OP_POP;
            end
            S_RESP: begin
                bus.o_rsp_valid = 1'b1;
                bus.o_rsp_err   = err_q;
            end
            default: begin
            end
        endcase
    end

    assign bus.o_req_ready = ready;
    assign bus.o_rdata     = rdata_q;

endmodule

// File: tb/tb_stack_access_unit.sv
// Randomized bench for stack_access_unit with a byte-array stack model.
// Responses are checked by a monitor against a scoreboard queue.

`ifndef SFR_OP_LEN
`define SFR_OP_LEN 4
`endif
`ifndef OP_SP_PUSH
`define OP_SP_PUSH 4'h1
`endif
`ifndef OP_SP_POP
`define OP_SP_POP 4'h2
`endif

module tb_stack_access_unit;

    localparam logic [7:0] TOP   = 8'h7F;
    localparam logic [7:0] FLOOR = 8'h08;
    localparam logic [`SFR_OP_LEN-1:0] OPU = `OP_SP_PUSH;
    localparam logic [`SFR_OP_LEN-1:0] OPO = `OP_SP_POP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_access_unit_if bus ();

    logic [7:0]             sp_reg;
    logic [`SFR_OP_LEN-1:0] sp_op;
    logic [7:0]             ram_addr;
    logic                   ram_we;
    logic [7:0]             ram_wdata;
    logic                   ram_re;
    logic [7:0]             ram_rdata = 8'h00;
    logic [7:0]             ram [256];

    stack_access_unit #(
        .STACK_TOP  (TOP),
        .STACK_FLOOR(FLOOR)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus),
        .i_sp       (sp_reg),
        .o_sp_op    (sp_op),
        .o_ram_addr (ram_addr),
        .o_ram_we   (ram_we),
        .o_ram_wdata(ram_wdata),
        .o_ram_re   (ram_re),
        .i_ram_rdata(ram_rdata)
    );

    // SP block: resets to the top, steps on the op cycle's closing edge.
    always @(posedge clk) begin
        if (rst) sp_reg <= 8'h7F;
        else if (sp_op == OPU) sp_reg <= sp_reg - 8'd1;
        else if (sp_op == OPO) sp_reg <= sp_reg + 8'd1;
    end

    // Internal RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          err;
        logic [15:0] rdata;
        logic [7:0]  sp;
        int          cyc;
    } exp_t;

    exp_t scb[$];

    logic [7:0]  ref_mem [256];
    int          ref_sp = 'h7F;
    logic [15:0] ref_rdata = 16'h0000;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Stack behaviour as a byte array plus a pointer.
    function automatic exp_t model(input bit pop, input bit two,
                                   input logic [15:0] wd, input int acc);
        exp_t e;
        int n;
        n = two ? 2 : 1;
        e.err = 1'b0;
        if (!pop) begin
            if (ref_sp < int'(FLOOR) + n - 1) begin
                e.err = 1'b1;
            end else begin
                ref_mem[ref_sp] = wd[7:0];
                if (two) ref_mem[ref_sp - 1] = wd[15:8];
                ref_sp = ref_sp - n;
            end
        end else begin
            if (ref_sp + n > int'(TOP)) begin
                e.err = 1'b1;
            end else begin
                if (two) ref_rdata = {ref_mem[ref_sp + 1], ref_mem[ref_sp + 2]};
                else     ref_rdata = {8'h00, ref_mem[ref_sp + 1]};
                ref_sp = ref_sp + n;
            end
        end
        e.rdata = ref_rdata;
        e.sp    = ref_sp[7:0];
        if (e.err)    e.cyc = acc + 2;
        else if (pop) e.cyc = acc + 2 + 2 * n;
        else          e.cyc = acc + 2 + n;
        return e;
    endfunction

    // Monitor: response scoreboard plus per-cycle RAM/SP strobe rules.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            if (bus.o_rsp_valid) begin
                if (scb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 expected none");
                end else begin
                    e = scb.pop_front();
                    chk("rsp_err", 32'(bus.o_rsp_err), 32'(e.err));
                    chk("rdata", 32'(bus.o_rdata), 32'(e.rdata));
                    chk("sp_after", 32'(sp_reg), 32'(e.sp));
                    chk("latency", 32'(cyc), 32'(e.cyc));
                end
            end
            if (sp_op != 0 || ram_we || ram_re) begin
                chk("op_code", 32'(sp_op == 0 || sp_op == OPU || sp_op == OPO), 32'd1);
                chk("we_vs_op", 32'(ram_we), 32'(sp_op == OPU));
                chk("re_vs_op", 32'(ram_re), 32'(sp_op == OPO));
                if (ram_we) chk("wr_addr", 32'(ram_addr), 32'(sp_reg));
                if (ram_re) chk("rd_addr", 32'(ram_addr), 32'(sp_reg + 8'd1));
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.o_req_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        ok = bus.o_req_ready;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got ready=0 expected 1");
        end
    endtask

    // Issue one request; a garbage request is held during the busy cycle.
    task automatic issue(input bit pop, input bit two, input logic [15:0] wd);
        bit ok;
        wait_ready(ok);
        if (ok) begin
            bus.i_req_valid = 1'b1;
            bus.i_req_pop   = pop;
            bus.i_req_two   = two;
            bus.i_wdata     = wd;
            scb.push_back(model(pop, two, wd, cyc));
            @(posedge clk);
            #1;
            bus.i_req_pop = ~pop;
            bus.i_req_two = 1'($urandom);
            bus.i_wdata   = 16'($urandom);
            @(posedge clk);
            #1;
            bus.i_req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (scb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (scb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", scb.size());
            scb.delete();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.o_req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.o_rsp_err), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.o_rdata), 32'd0);
        chk({tag, "_we_re"}, {30'd0, ram_we, ram_re}, 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(ram_wdata), 32'd0);
        chk({tag, "_sp_op"}, 32'(sp_op), 32'd0);
    endtask

    initial begin
        bit ok;
        int t;
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            ram[i]     = v;
            ref_mem[i] = v;
        end
        bus.i_req_valid = 1'b0;
        bus.i_req_pop   = 1'b0;
        bus.i_req_two   = 1'b0;
        bus.i_wdata     = 16'h0000;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        issue(1'b0, 1'b0, 16'h00A5);
        issue(1'b0, 1'b1, 16'h1234);
        issue(1'b1, 1'b1, 16'h0000);
        issue(1'b1, 1'b0, 16'h0000);
        issue(1'b0, 1'b0, 16'h0077);
        for (int i = 0; i < 59; i++) issue(1'b0, 1'b1, 16'($urandom));
        issue(1'b0, 1'b1, 16'hBEEF);
        issue(1'b0, 1'b0, 16'h00C3);
        issue(1'b0, 1'b0, 16'h005A);
        drain();
        chk("sp_at_floor", 32'(sp_reg), 32'h07);

        // Reset while the first byte of a 2-byte pop is being captured.
        wait_ready(ok);
        if (ok) begin
            bus.i_req_valid = 1'b1;
            bus.i_req_pop   = 1'b1;
            bus.i_req_two   = 1'b1;
            @(posedge clk);
            #1;
            bus.i_req_valid = 1'b0;
            t = 0;
            @(negedge clk);
            while (!ram_re && t < 10) begin
                @(negedge clk);
                t++;
            end
            chk("mid_pop_re", 32'(ram_re), 32'd1);
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            ref_sp    = 'h7F;
            ref_rdata = 16'h0000;
            chk_reset_outputs("midrst");
            chk("midrst_sp", 32'(sp_reg), 32'h7F);
        end
        issue(1'b0, 1'b0, 16'h0042);
        issue(1'b1, 1'b0, 16'h0000);

        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom_range(0, 99) < 30), 1'($urandom), 16'($urandom));
        end
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom_range(0, 99) < 60), 1'($urandom), 16'($urandom));
        end
        drain();

        for (int a = int'(FLOOR); a <= int'(TOP); a++) begin
            chk($sformatf("ram_%02h", a), 32'(ram[a]), 32'(ref_mem[a]));
        end
        chk("sp_final", 32'(sp_reg), 32'(ref_sp[7:0]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
